// File: rtl/vend_pkg.sv
// Shared coin encodings, coin values and FSM state type for the vending controller.
package vend_pkg;

    localparam int unsigned COIN_VAL_W = 5;

    localparam logic [2:0] COIN_Q = 3'b100;
    localparam logic [2:0] COIN_D = 3'b010;
    localparam logic [2:0] COIN_N = 3'b001;

    localparam logic [COIN_VAL_W-1:0] VAL_Q = 5'd25;
    localparam logic [COIN_VAL_W-1:0] VAL_D = 5'd10;
    localparam logic [COIN_VAL_W-1:0] VAL_N = 5'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } state_t;

    // Largest coin not exceeding the amount; 0 when nothing fits.
    function automatic logic [2:0] greedy_coin(input logic [31:0] amt);
        if (amt >= 32'(VAL_Q))      return COIN_Q;
        else if (amt >= 32'(VAL_D)) return COIN_D;
        else if (amt >= 32'(VAL_N)) return COIN_N;
        else                        return 3'b000;
    endfunction

endpackage

// File: rtl/coin_decode.sv
// One-hot coin to cent value; anything not exactly one-hot is flagged invalid.
module coin_decode
    import vend_pkg::*;
(
    input  logic [2:0]            coin,
    output logic [COIN_VAL_W-1:0] value,
    output logic                  invalid
);

    always_comb begin
        value   = '0;
        invalid = 1'b0;
        case (coin)
            COIN_Q:  value = VAL_Q;
            COIN_D:  value = VAL_D;
            COIN_N:  value = VAL_N;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/vend_controller.sv
// Vending machine controller: coin credit, product vend and greedy change return.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned N_ITEMS    = 4,
    parameter int unsigned PRICE_W    = 8,
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned MAX_CREDIT = 100
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         coin_valid,
    input  logic [2:0]                   coin,
    input  logic                         sel_valid,
    input  logic [$clog2(N_ITEMS)-1:0]   sel,
    input  logic [N_ITEMS*PRICE_W-1:0]   prices,
    input  logic                         cancel,
    input  logic                         change_ready,
    output logic                         vend,
    output logic [$clog2(N_ITEMS)-1:0]   vend_item,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         busy,
    output logic                         change_valid,
    output logic [2:0]                   change_coin,
    output logic                         coin_reject,
    output logic                         sel_reject
);

    state_t                state;
    logic [COIN_VAL_W-1:0] in_val;
    logic [COIN_VAL_W-1:0] chg_val;
    logic                  in_invalid;
    logic                  chg_invalid;
    logic [PRICE_W-1:0]    sel_price;
    logic                  sel_in_range;
    logic                  sel_affordable;
    logic                  coin_fits;
    logic [CREDIT_W-1:0]   credit_after_change;

    coin_decode u_in_decode (
        .coin    (coin),
        .value   (in_val),
        .invalid (in_invalid)
    );

    coin_decode u_chg_decode (
        .coin    (change_coin),
        .value   (chg_val),
        .invalid (chg_invalid)
    );

    always_comb begin
        sel_in_range = 32'(sel) < N_ITEMS;
        sel_price    = '0;
        if (sel_in_range)
            sel_price = prices[32'(sel)*PRICE_W +: PRICE_W];
        sel_affordable      = 32'(credit) >= 32'(sel_price);
        coin_fits           = (32'(credit) + 32'(in_val)) <= MAX_CREDIT;
        credit_after_change = chg_invalid ? credit : credit - CREDIT_W'(chg_val);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            credit       <= '0;
            vend         <= 1'b0;
            vend_item    <= '0;
            busy         <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= '0;
            coin_reject  <= 1'b0;
            sel_reject   <= 1'b0;
        end else begin
            vend        <= 1'b0;
            coin_reject <= 1'b0;
            sel_reject  <= 1'b0;
            case (state)
                S_IDLE, S_CREDIT: begin
                    // Priority cancel > coin > selection; lower-priority requests are dropped.
                    if (cancel && state == S_CREDIT) begin
                        coin_reject  <= coin_valid;
                        state        <= S_CHANGE;
                        busy         <= 1'b1;
                        change_valid <= 1'b1;
                        change_coin  <= greedy_coin(32'(credit));
                    end else if (coin_valid) begin
                        if (in_invalid || !coin_fits) begin
                            coin_reject <= 1'b1;
                        end else begin
                            credit <= credit + CREDIT_W'(in_val);
                            state  <= S_CREDIT;
                        end
                    end else if (sel_valid) begin
                        if (sel_in_range && sel_affordable) begin
                            credit    <= credit - CREDIT_W'(sel_price);
                            vend      <= 1'b1;
                            vend_item <= sel;
                            busy      <= 1'b1;
                            state     <= S_VEND;
                        end else begin
                            sel_reject <= 1'b1;
                        end
                    end
                end
                S_VEND: begin
                    coin_reject <= coin_valid;
                    vend_item   <= '0;
                    if (credit == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state        <= S_CHANGE;
                        change_valid <= 1'b1;
                        change_coin  <= greedy_coin(32'(credit));
                    end
                end
                S_CHANGE: begin
                    coin_reject <= coin_valid;
                    if (change_ready) begin
                        credit <= credit_after_change;
                        if (credit_after_change == '0) begin
                            state        <= S_IDLE;
                            busy         <= 1'b0;
                            change_valid <= 1'b0;
                            change_coin  <= '0;
                        end else begin
                            change_coin <= greedy_coin(32'(credit_after_change));
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 The block SHALL have parameter N_ITEMS, default 4, number of selectable products (>=2).
REQ-002 The block SHALL have parameter PRICE_W, default 8, width of each price field in cents.
REQ-003 The block SHALL have parameter CREDIT_W, default 8, width of the credit register in cents.
REQ-004 The block SHALL have parameter MAX_CREDIT, default 100, credit ceiling in cents (multiple of 5, < 2**CREDIT_W).
REQ-005 The block SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port coin_valid, input, 1, coin present this cycle.
REQ-008 The block SHALL have port coin, input, 3, one-hot coin: 3'b100 quarter (25), 3'b010 dime (10), 3'b001 nickel (5).
REQ-009 The block SHALL have port sel_valid, input, 1, product selection request.
REQ-010 The block SHALL have port sel, input, $clog2(N_ITEMS), selected item index.
REQ-011 The block SHALL have port prices, input, N_ITEMS*PRICE_W, flat price table; item i at bits [i*PRICE_W +: PRICE_W].
REQ-012 The block SHALL have port cancel, input, 1, refund request.
REQ-013 The block SHALL have port change_ready, input, 1, change dispenser accepts a coin.
REQ-014 The block SHALL have outputs vend (1, one-cycle dispense pulse), vend_item ($clog2(N_ITEMS), index dispensed, valid with vend), credit (CREDIT_W, current credit), busy (1, state is VEND or CHANGE).
REQ-015 The block SHALL have outputs change_valid (1), change_coin (3, one-hot, same encoding as coin), coin_reject (1, pulse), sel_reject (1, pulse).

Function
REQ-016 The FSM SHALL have states IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE.
REQ-017 A coin SHALL be accepted in IDLE/CREDIT only; an accepted coin_valid at edge t SHALL make credit+value visible after edge t, and the FSM SHALL enter CREDIT.
REQ-018 A coin that is not one-hot, that would exceed MAX_CREDIT, or that arrives in VEND/CHANGE SHALL leave credit unchanged and assert coin_reject for exactly the following cycle.
REQ-019 In IDLE/CREDIT, sel_valid with sel<N_ITEMS and credit>=price SHALL enter VEND: credit<=credit-price, vend=1 and vend_item=sel for that one cycle.
REQ-020 sel_valid with sel>=N_ITEMS or credit<price SHALL be ignored, and sel_reject SHALL pulse for the following cycle; a price of 0 SHALL vend.
REQ-021 From VEND, the FSM SHALL go to IDLE if credit==0, else to CHANGE.
REQ-022 In CHANGE, change_valid SHALL be 1 and change_coin SHALL be the largest coin <= credit (greedy 25/10/5).
REQ-023 On change_valid&change_ready, credit SHALL decrease by that coin value; the FSM SHALL return to IDLE when credit reaches 0.
REQ-024 change_coin SHALL hold stable while change_valid&!change_ready.
REQ-025 cancel in CREDIT SHALL enter CHANGE with full credit as refund; cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-026 Same-cycle priority SHALL be cancel > coin > selection; a dropped selection SHALL NOT assert sel_reject, and a coin dropped due to cancel SHALL assert coin_reject.
REQ-027 Credit arithmetic SHALL never wrap; the checks in REQ-018 and REQ-019 guarantee this.

Reset
REQ-028 Reset SHALL force IDLE, credit=0, and vend, change_valid, change_coin, coin_reject, sel_reject, busy, vend_item all 0, in any state including mid-CHANGE (pending change is discarded).
REQ-029 Inputs SHALL be ignored in the cycle reset is high.

Structure
REQ-030 Package vend_pkg SHALL hold coin encodings, coin values (25/10/5) and the state enum.
REQ-031 Sub-module coin_decode SHALL map the one-hot coin to a value plus an invalid flag, and SHALL be reused for change_coin-to-value.

Verification
REQ-032 Reset, then coins Q,Q (credit 50), sel=1 with price 30 -> vend pulse with vend_item=1; CHANGE emits D then D with change_ready=1; credit 0; IDLE.
REQ-033 Credit 90, insert Q -> coin_reject next cycle; credit stays 90; coin 3'b110 -> coin_reject.
REQ-034 Credit 10, sel price 15 -> sel_reject; credit 10; sel=N_ITEMS -> sel_reject.
REQ-035 Credit 35, cancel together with a coin -> coin_reject; refund Q then D; with change_ready held low 5 cycles, change_coin stays Q.
REQ-036 Reset asserted mid-CHANGE (credit 15 remaining) -> next cycle credit=0, change_valid=0, IDLE.
REQ-037 Exact payment, credit 30, price 30 -> vend, then directly IDLE; change_valid never asserted.
